csr_ex_ctrl: RTL and testbench
==============================

Name: csr_ex_ctrl

Overview:
Exception/interrupt CSR controller for the LoongArch pipeline. It owns the exception-related CSRs and the stable timer, and provides has_int to the WB-stage exception encoder. It commits exception entry (wb_ex, wb_ecode, wb_esubcode from WB) and ertn return, and supplies redirect targets to fetch. It also serves CSR read/write for csrrd/csrwr/csrxchg.

Parameters:
TID_RESET, 32'h0, reset value of TID (timer ID).
TIMER_W, 32, width of TVAL counter; InitVal field is TCFG[TIMER_W-1:2].

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
csr_re  in  1  read enable (qualifies csr_rvalue only)
csr_num  in  14  CSR address for read/write
csr_rvalue  out  32  combinational read data
csr_we  in  1  write enable
csr_wmask  in  32  bit write mask
csr_wvalue  in  32  write data
wb_ex  in  1  exception commits this cycle
wb_ecode  in  6  exception code
wb_esubcode  in  9  exception subcode (8-bit encoder output zero-extended)
wb_pc  in  32  PC of the excepting instruction
wb_vaddr  in  32  faulting data address (ALE)
ertn_flush  in  1  ertn commits this cycle
hw_int_in  in  8  hardware interrupt lines, level
ipi_int_in  in  1  inter-processor interrupt, level
has_int  out  1  pending enabled interrupt to the WB encoder
ex_entry  out  32  exception target = EENTRY
ertn_entry  out  32  return target = ERA

Behaviour:
- CSRs (num): CRMD 0x0 {DA[3],IE[2],PLV[1:0]}; PRMD 0x1 {PIE[2],PPLV[1:0]}; ECFG 0x4 {LIE[12:0], LIE[10]=0}; ESTAT 0x5 {EsubCode[30:22],Ecode[21:16],IS[12:0]}; ERA 0x6; BADV 0x7; EENTRY 0xC {VA[31:6]}; TID 0x40; TCFG 0x41 {InitVal[TIMER_W-1:2],Periodic[1],En[0]}; TVAL 0x42 (read-only); TICLR 0x44 (read 0). Unimplemented bits read 0.
- Reset: CRMD=0x8 (DA=1, PLV=0, IE=0); PRMD, ECFG, ESTAT, ERA, BADV, EENTRY, TCFG=0; TID=TID_RESET; TVAL all-ones; has_int=0.
- Read: combinational on csr_num; unknown num -> 0.
- Write: field <= (old & ~csr_wmask) | (csr_wvalue & csr_wmask), writable fields only. Software-writable ESTAT bits: IS[1:0] only. Takes effect next cycle.
- Priority each cycle: wb_ex > ertn_flush > csr_we. Lower-priority requests in the same cycle are dropped.
- Exception entry (wb_ex=1), one cycle:
  - PRMD.PPLV<=CRMD.PLV, PRMD.PIE<=CRMD.IE; CRMD.PLV<=0, CRMD.IE<=0.
  - ERA<=wb_pc; ESTAT.Ecode<=wb_ecode; ESTAT.EsubCode<=wb_esubcode.
  - BADV<=wb_pc if ecode=0x08 (ADEF); BADV<=wb_vaddr if ecode=0x09 (ALE); otherwise unchanged.
- ertn (ertn_flush=1, wb_ex=0): CRMD.PLV<=PRMD.PPLV, CRMD.IE<=PRMD.PIE.
- Interrupt sampling every cycle: IS[9:2]<=hw_int_in; IS[12]<=ipi_int_in; IS[10]=0.
- has_int = CRMD.IE & |(ECFG.LIE & ESTAT.IS); combinational from registered state only.
- ex_entry={EENTRY.VA,6'b0}; ertn_entry=ERA; combinational. A write to these CSRs is visible the next cycle.
- Timer:
  - TCFG write: TVAL<={new InitVal,2'b00}, same edge.
  - Else if En and TVAL!=0: TVAL decrements by 1.
  - When TVAL goes from 1 to 0 with En=1: IS[11]<=1.
  - En=1, Periodic=1, TVAL==0: TVAL reloads {InitVal,2'b00} next cycle. Non-periodic: TVAL stays 0 and does not wrap.
  - En=0: TVAL holds.
- TICLR write with wvalue[0]&wmask[0]=1 clears IS[11]. A timer set on the same edge wins (IS[11]=1).
- Reset mid-countdown or mid-exception returns all state to reset values the next edge; no partial entry persists.

Test Plan:
- Reset -> CRMD reads 0x8, TID reads TID_RESET, has_int=0, TVAL reads 0xFFFFFFFF.
- Set CRMD.PLV=3, IE=1; pulse wb_ex, ecode 0x0B, wb_pc 0x1c000100 -> CRMD PLV=0 IE=0; PRMD PPLV=3 PIE=1; ERA=0x1c000100; ESTAT[21:16]=0x0B; BADV unchanged. Then ertn_flush -> PLV=3, IE=1.
- wb_ex ecode 0x09, wb_vaddr 0x1234 -> BADV=0x1234. wb_ex ecode 0x08, wb_pc 0x1c000002 -> BADV=0x1c000002. wb_ex, ertn_flush and csr_we to CRMD together -> only the exception effect occurs.
- Write TCFG InitVal=2 (value 0xB: Periodic=1, En=1) -> TVAL=8, then 7 … 0. IS[11]=1 on the 1->0 edge, then reload to 8. With ECFG.LIE[11]=1 and IE=1, has_int=1. TICLR write -> IS[11]=0. TICLR on the same edge as 1->0 -> IS[11]=1.
- Write ESTAT with wmask 0xFFFFFFFF, value 0x3 -> IS[1:0]=3, Ecode unchanged. hw_int_in=0x01 -> IS[2]=1 next cycle, and has_int follows LIE[2] & IE.
- Read csr_num 0x3 and 0x44 -> 0. Masked write to EENTRY, value 0x1c008000 -> ex_entry=0x1c008000 next cycle.

Source files
------------

// File: rtl/csr_ex_ctrl.sv
// ---------------------------------------------------------------------------
// csr_ex_ctrl
//   Exception/interrupt CSR block for the LoongArch pipeline. Holds CRMD,
//   PRMD, ECFG, ESTAT, ERA, BADV, EENTRY, TID, TCFG, TVAL and TICLR. Commits
//   exception entry and ertn return from WB, samples the interrupt lines,
//   runs the stable timer and raises has_int for the WB exception encoder.
//
// Ports
//   clk, reset                     rising-edge clock, synchronous active-high reset
//   csr_re, csr_num, csr_rvalue    combinational CSR read (rvalue is 0 when csr_re=0)
//   csr_we, csr_wmask, csr_wvalue  masked CSR write, visible the next cycle
//   wb_ex, wb_ecode, wb_esubcode,
//   wb_pc, wb_vaddr                exception commit from WB
//   ertn_flush                     ertn commit from WB
//   hw_int_in, ipi_int_in          level interrupt lines, sampled every cycle
//   has_int                        enabled interrupt pending
//   ex_entry, ertn_entry           redirect targets for fetch
// ---------------------------------------------------------------------------
module csr_ex_ctrl #(
    parameter logic [31:0] TID_RESET = 32'h0,
    parameter int unsigned TIMER_W   = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        csr_re,
    input  logic [13:0] csr_num,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_vaddr,
    input  logic        ertn_flush,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic        has_int,
    output logic [31:0] ex_entry,
    output logic [31:0] ertn_entry
);

    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ECFG   = 14'h004;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_BADV   = 14'h007;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;
    localparam logic [13:0] CSR_TID    = 14'h040;
    localparam logic [13:0] CSR_TCFG   = 14'h041;
    localparam logic [13:0] CSR_TVAL   = 14'h042;
    localparam logic [13:0] CSR_TICLR  = 14'h044;

    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;

    localparam logic [TIMER_W-1:0] TVAL_ONE = 1;

    logic [3:0]         crmd_q,   crmd_d;    // {DA, IE, PLV[1:0]}
    logic [2:0]         prmd_q,   prmd_d;    // {PIE, PPLV[1:0]}
    logic [12:0]        lie_q,    lie_d;
    logic [12:0]        is_q,     is_d;
    logic [5:0]         ecode_q,  ecode_d;
    logic [8:0]         esub_q,   esub_d;
    logic [31:0]        era_q,    era_d;
    logic [31:0]        badv_q,   badv_d;
    logic [25:0]        eentry_q, eentry_d;
    logic [31:0]        tid_q,    tid_d;
    logic [TIMER_W-1:0] tcfg_q,   tcfg_d;
    logic [TIMER_W-1:0] tval_q,   tval_d;

    logic [31:0] rd_raw;      // current image of the addressed CSR
    logic [31:0] wnew;        // image after applying the masked write
    logic        wr_en;       // write survives the exception/ertn priority
    logic        timer_fire;

    // Read mux doubles as the "old value" for the masked write merge.
    always_comb begin
        rd_raw = 32'h0;
        unique case (csr_num)
            CSR_CRMD:   rd_raw = {28'h0, crmd_q};
            CSR_PRMD:   rd_raw = {29'h0, prmd_q};
            CSR_ECFG:   rd_raw = {19'h0, lie_q};
            CSR_ESTAT:  rd_raw = {1'b0, esub_q, ecode_q, 3'b000, is_q};
            CSR_ERA:    rd_raw = era_q;
            CSR_BADV:   rd_raw = badv_q;
            CSR_EENTRY: rd_raw = {eentry_q, 6'h0};
            CSR_TID:    rd_raw = tid_q;
            CSR_TCFG:   rd_raw = 32'(tcfg_q);
            CSR_TVAL:   rd_raw = 32'(tval_q);
            default:    rd_raw = 32'h0;
        endcase
    end

    assign csr_rvalue = csr_re ? rd_raw : 32'h0;
    assign wnew       = (rd_raw & ~csr_wmask) | (csr_wvalue & csr_wmask);
    assign wr_en      = csr_we & ~wb_ex & ~ertn_flush;

    assign has_int    = crmd_q[2] & (|(lie_q & is_q));
    assign ex_entry   = {eentry_q, 6'h0};
    assign ertn_entry = era_q;

    always_comb begin
        crmd_d     = crmd_q;
        prmd_d     = prmd_q;
        lie_d      = lie_q;
        is_d       = is_q;
        ecode_d    = ecode_q;
        esub_d     = esub_q;
        era_d      = era_q;
        badv_d     = badv_q;
        eentry_d   = eentry_q;
        tid_d      = tid_q;
        tcfg_d     = tcfg_q;
        tval_d     = tval_q;
        timer_fire = 1'b0;

        // Level interrupt lines are resampled unconditionally.
        is_d[9:2]  = hw_int_in;
        is_d[10]   = 1'b0;
        is_d[12]   = ipi_int_in;

        // Timer: a TCFG write reloads immediately; otherwise count down
        // while enabled, firing on 1->0. A periodic timer sitting at 0
        // reloads; a one-shot one parks at 0.
        if (wr_en && csr_num == CSR_TCFG) begin
            tval_d = {wnew[TIMER_W-1:2], 2'b00};
        end else if (tcfg_q[0]) begin
            if (tval_q != '0) begin
                tval_d     = tval_q - TVAL_ONE;
                timer_fire = (tval_q == TVAL_ONE);
            end else if (tcfg_q[1]) begin
                tval_d = {tcfg_q[TIMER_W-1:2], 2'b00};
            end
        end

        if (wb_ex) begin
            prmd_d  = crmd_q[2:0];
            crmd_d  = {crmd_q[3], 3'b000};
            era_d   = wb_pc;
            ecode_d = wb_ecode;
            esub_d  = wb_esubcode;
            if (wb_ecode == ECODE_ADEF) begin
                badv_d = wb_pc;
            end else if (wb_ecode == ECODE_ALE) begin
                badv_d = wb_vaddr;
            end
        end else if (ertn_flush) begin
            crmd_d = {crmd_q[3], prmd_q};
        end else if (csr_we) begin
            unique case (csr_num)
                CSR_CRMD:   crmd_d   = wnew[3:0];
                CSR_PRMD:   prmd_d   = wnew[2:0];
                CSR_ECFG:   lie_d    = {wnew[12:11], 1'b0, wnew[9:0]};
                CSR_ESTAT:  is_d[1:0] = wnew[1:0];
                CSR_ERA:    era_d    = wnew;
                CSR_BADV:   badv_d   = wnew;
                CSR_EENTRY: eentry_d = wnew[31:6];
                CSR_TID:    tid_d    = wnew;
                CSR_TCFG:   tcfg_d   = wnew[TIMER_W-1:0];
                CSR_TICLR: begin
                    if (csr_wmask[0] & csr_wvalue[0]) begin
                        is_d[11] = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        // A timer expiry on the same edge as a TICLR must not be lost.
        if (timer_fire) begin
            is_d[11] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crmd_q   <= 4'h8;
            prmd_q   <= '0;
            lie_q    <= '0;
            is_q     <= '0;
            ecode_q  <= '0;
            esub_q   <= '0;
            era_q    <= '0;
            badv_q   <= '0;
            eentry_q <= '0;
            tid_q    <= TID_RESET;
            tcfg_q   <= '0;
            tval_q   <= '1;
        end else begin
            crmd_q   <= crmd_d;
            prmd_q   <= prmd_d;
            lie_q    <= lie_d;
            is_q     <= is_d;
            ecode_q  <= ecode_d;
            esub_q   <= esub_d;
            era_q    <= era_d;
            badv_q   <= badv_d;
            eentry_q <= eentry_d;
            tid_q    <= tid_d;
            tcfg_q   <= tcfg_d;
            tval_q   <= tval_d;
        end
    end

endmodule

// File: tb/tb_csr_ex_ctrl.sv
// ---------------------------------------------------------------------------
// tb_csr_ex_ctrl
//   Scoreboard bench for csr_ex_ctrl. The stimulus side keeps a model of the
//   CSR images as whole 32-bit words, pushes the expected read/has_int/
//   redirect values for each cycle, then advances the model. A monitor on
//   the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_csr_ex_ctrl;

    localparam logic [31:0] TID_RST = 32'hA5A5_0001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        csr_re = 1'b0;
    logic [13:0] csr_num = '0;
    logic [31:0] csr_rvalue;
    logic        csr_we = 1'b0;
    logic [31:0] csr_wmask = '0;
    logic [31:0] csr_wvalue = '0;
    logic        wb_ex = 1'b0;
    logic [5:0]  wb_ecode = '0;
    logic [8:0]  wb_esubcode = '0;
    logic [31:0] wb_pc = '0;
    logic [31:0] wb_vaddr = '0;
    logic        ertn_flush = 1'b0;
    logic [7:0]  hw_int_in = '0;
    logic        ipi_int_in = 1'b0;
    logic        has_int;
    logic [31:0] ex_entry;
    logic [31:0] ertn_entry;

    csr_ex_ctrl #(.TID_RESET(TID_RST), .TIMER_W(32)) dut (
        .clk(clk), .reset(reset), .csr_re(csr_re), .csr_num(csr_num),
        .csr_rvalue(csr_rvalue), .csr_we(csr_we), .csr_wmask(csr_wmask),
        .csr_wvalue(csr_wvalue), .wb_ex(wb_ex), .wb_ecode(wb_ecode),
        .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
        .ertn_flush(ertn_flush), .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
        .has_int(has_int), .ex_entry(ex_entry), .ertn_entry(ertn_entry)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] num;
        logic [31:0] rv;
        logic        hi;
        logic [31:0] exe;
        logic [31:0] ere;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Model: whole-word CSR images; only implemented bits are ever set.
    logic [31:0] m_crmd, m_prmd, m_ecfg, m_estat, m_era, m_badv;
    logic [31:0] m_eentry, m_tid, m_tcfg, m_tval;

    function automatic void model_reset();
        m_crmd = 32'h8; m_prmd = 0; m_ecfg = 0; m_estat = 0; m_era = 0;
        m_badv = 0; m_eentry = 0; m_tid = TID_RST; m_tcfg = 0;
        m_tval = 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] m_read(input logic [13:0] n);
        case (n)
            14'h00: return m_crmd;
            14'h01: return m_prmd;
            14'h04: return m_ecfg;
            14'h05: return m_estat;
            14'h06: return m_era;
            14'h07: return m_badv;
            14'h0C: return m_eentry;
            14'h40: return m_tid;
            14'h41: return m_tcfg;
            14'h42: return m_tval;
            default: return 32'h0;
        endcase
    endfunction

    // Bits software may change in each CSR.
    function automatic logic [31:0] wr_bits(input logic [13:0] n);
        case (n)
            14'h00: return 32'h0000_000F;
            14'h01: return 32'h0000_0007;
            14'h04: return 32'h0000_1BFF;
            14'h05: return 32'h0000_0003;
            14'h06, 14'h07, 14'h40, 14'h41: return 32'hFFFF_FFFF;
            14'h0C: return 32'hFFFF_FFC0;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] merged(input logic [31:0] old, input logic [13:0] n);
        logic [31:0] m;
        m = csr_wmask & wr_bits(n);
        return (old & ~m) | (csr_wvalue & m);
    endfunction

    function automatic void model_next();
        logic [31:0] n_crmd, n_prmd, n_ecfg, n_estat, n_era, n_badv;
        logic [31:0] n_eentry, n_tid, n_tcfg, n_tval;
        logic        fire;
        if (reset) begin
            model_reset();
            return;
        end
        n_crmd = m_crmd; n_prmd = m_prmd; n_ecfg = m_ecfg; n_era = m_era;
        n_badv = m_badv; n_eentry = m_eentry; n_tid = m_tid; n_tcfg = m_tcfg;
        n_tval = m_tval; fire = 1'b0;
        n_estat = (m_estat & ~32'h13FC) | {19'h0, ipi_int_in, 2'b00, hw_int_in, 2'b00};

        if (csr_we && !wb_ex && !ertn_flush && csr_num == 14'h41) begin
            n_tval = merged(m_tcfg, 14'h41) & 32'hFFFF_FFFC;
        end else if (m_tcfg[0]) begin
            if (m_tval != 0) begin
                n_tval = m_tval - 1;
                fire = (m_tval == 1);
            end else if (m_tcfg[1]) begin
                n_tval = m_tcfg & 32'hFFFF_FFFC;
            end
        end

        if (wb_ex) begin
            n_prmd = m_crmd & 32'h7;
            n_crmd = m_crmd & 32'h8;
            n_era  = wb_pc;
            n_estat = (n_estat & ~32'h7FFF_0000) | ({17'h0, wb_esubcode, wb_ecode} << 16);
            if (wb_ecode == 6'h08) n_badv = wb_pc;
            else if (wb_ecode == 6'h09) n_badv = wb_vaddr;
        end else if (ertn_flush) begin
            n_crmd = (m_crmd & 32'h8) | (m_prmd & 32'h7);
        end else if (csr_we) begin
            case (csr_num)
                14'h00: n_crmd = merged(m_crmd, csr_num);
                14'h01: n_prmd = merged(m_prmd, csr_num);
                14'h04: n_ecfg = merged(m_ecfg, csr_num);
                14'h05: n_estat = merged(n_estat, csr_num);
                14'h06: n_era = merged(m_era, csr_num);
                14'h07: n_badv = merged(m_badv, csr_num);
                14'h0C: n_eentry = merged(m_eentry, csr_num);
                14'h40: n_tid = merged(m_tid, csr_num);
                14'h41: n_tcfg = merged(m_tcfg, csr_num);
                14'h44: if (csr_wvalue[0] && csr_wmask[0]) n_estat[11] = 1'b0;
                default: ;
            endcase
        end
        if (fire) n_estat[11] = 1'b1;

        m_crmd = n_crmd; m_prmd = n_prmd; m_ecfg = n_ecfg; m_estat = n_estat;
        m_era = n_era; m_badv = n_badv; m_eentry = n_eentry; m_tid = n_tid;
        m_tcfg = n_tcfg; m_tval = n_tval;
    endfunction

    // Issue the currently driven inputs for one cycle.
    task automatic step();
        exp_t e;
        if (csr_re) begin
            e.num = csr_num;
            e.rv  = m_read(csr_num);
            e.hi  = m_crmd[2] & (|(m_ecfg[12:0] & m_estat[12:0]));
            e.exe = m_eentry & 32'hFFFF_FFC0;
            e.ere = m_era;
            sb.push_back(e);
        end
        model_next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; csr_we = 1'b0; wb_ex = 1'b0; ertn_flush = 1'b0;
        csr_re = 1'b1;
    endtask

    task automatic rd(input logic [13:0] n);
        idle(); csr_num = n; step();
    endtask

    task automatic wr(input logic [13:0] n, input logic [31:0] m, input logic [31:0] v);
        idle(); csr_we = 1'b1; csr_num = n; csr_wmask = m; csr_wvalue = v; step();
    endtask

    task automatic exc(input logic [5:0] ec, input logic [31:0] pc, input logic [31:0] va);
        idle(); wb_ex = 1'b1; wb_ecode = ec; wb_esubcode = 9'h0; wb_pc = pc;
        wb_vaddr = va; csr_num = 14'h5; step();
    endtask

    task automatic chk(input string nm, input logic [13:0] n,
                       input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s csr_num=0x%0h got=0x%08h expected=0x%08h", nm, n, act, expv);
        end
    endtask

    // Monitor: compare whenever the DUT presents a qualified read.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (csr_re) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard_empty got=read expected=none");
                end else begin
                    e = sb.pop_front();
                    chk("csr_rvalue", e.num, csr_rvalue, e.rv);
                    chk("has_int", e.num, {31'h0, has_int}, {31'h0, e.hi});
                    chk("ex_entry", e.num, ex_entry, e.exe);
                    chk("ertn_entry", e.num, ertn_entry, e.ere);
                end
            end
        end
    end

    function automatic logic [13:0] pick_num();
        case ($urandom_range(0, 12))
            0: return 14'h00;  1: return 14'h01;  2: return 14'h03;
            3: return 14'h04;  4: return 14'h05;  5: return 14'h06;
            6: return 14'h07;  7: return 14'h0C;  8: return 14'h40;
            9: return 14'h41;  10: return 14'h42; 11: return 14'h44;
            default: return 14'($urandom);
        endcase
    endfunction

    initial begin
        int guard;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();

        // Reset values.
        rd(14'h00); rd(14'h40); rd(14'h42);

        // Exception entry and return.
        wr(14'h00, 32'hF, 32'h7);
        exc(6'h0B, 32'h1c00_0100, 32'h0);
        rd(14'h00); rd(14'h01); rd(14'h06); rd(14'h05); rd(14'h07);
        idle(); ertn_flush = 1'b1; csr_num = 14'h0; step();
        rd(14'h00);

        // BADV capture for ALE and ADEF.
        exc(6'h09, 32'h1c00_0200, 32'h1234); rd(14'h07);
        exc(6'h08, 32'h1c00_0002, 32'h5678); rd(14'h07);

        // Exception beats ertn and CSR write in the same cycle.
        wr(14'h00, 32'hF, 32'h7);
        wr(14'h01, 32'h7, 32'h6);
        idle(); wb_ex = 1'b1; ertn_flush = 1'b1; csr_we = 1'b1; csr_num = 14'h0;
        csr_wmask = 32'hFFFF_FFFF; csr_wvalue = 32'hF; wb_ecode = 6'h0B;
        wb_pc = 32'h1c00_0300; step();
        rd(14'h00); rd(14'h01);

        // Periodic timer with interrupt.
        wr(14'h04, 32'hFFFF_FFFF, 32'h1FFF);
        rd(14'h04);
        wr(14'h00, 32'h4, 32'h4);
        wr(14'h41, 32'hFFFF_FFFF, 32'hB);
        for (int i = 0; i < 12; i++) rd(14'h42);
        rd(14'h05);
        wr(14'h44, 32'h1, 32'h1);
        rd(14'h05);
        guard = 0;
        while (m_tval != 1 && guard < 40) begin rd(14'h42); guard++; end
        wr(14'h44, 32'h1, 32'h1);   // same edge as 1->0
        rd(14'h05); rd(14'h42);

        // Software IS bits and a hardware line.
        wr(14'h44, 32'h1, 32'h1);
        wr(14'h05, 32'hFFFF_FFFF, 32'h3);
        rd(14'h05);
        wr(14'h05, 32'h3, 32'h0);
        hw_int_in = 8'h01;
        rd(14'h05); rd(14'h05);
        wr(14'h00, 32'h4, 32'h0);
        rd(14'h05);
        hw_int_in = 8'h00;

        // Unimplemented / read-zero addresses and EENTRY.
        rd(14'h03); rd(14'h44);
        wr(14'h0C, 32'hFFFF_FFFF, 32'h1c00_8000);
        rd(14'h0C);

        // Reset in the middle of a countdown.
        wr(14'h41, 32'hFFFF_FFFF, (32'd5 << 2) | 32'h1);
        rd(14'h42); rd(14'h42);
        idle(); reset = 1'b1; csr_num = 14'h42; step();
        rd(14'h42); rd(14'h00); rd(14'h41);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            idle();
            csr_re  = ($urandom_range(0, 9) != 0);
            csr_num = pick_num();
            reset   = ($urandom_range(0, 299) == 0);
            wb_ex   = ($urandom_range(0, 19) == 0);
            ertn_flush = ($urandom_range(0, 19) == 0);
            csr_we  = ($urandom_range(0, 2) == 0);
            csr_wmask  = $urandom_range(0, 1) ? 32'hFFFF_FFFF : $urandom;
            csr_wvalue = $urandom;
            if (csr_num == 14'h41) begin
                csr_wmask  = 32'hFFFF_FFFF;
                csr_wvalue = (32'($urandom_range(0, 6)) << 2) | 32'($urandom_range(0, 3));
            end
            case ($urandom_range(0, 3))
                0: wb_ecode = 6'h08;
                1: wb_ecode = 6'h09;
                2: wb_ecode = 6'h0B;
                default: wb_ecode = 6'($urandom);
            endcase
            wb_esubcode = 9'($urandom_range(0, 255));
            wb_pc    = $urandom;
            wb_vaddr = $urandom;
            if ($urandom_range(0, 9) == 0) hw_int_in = 8'($urandom);
            if ($urandom_range(0, 19) == 0) ipi_int_in = ~ipi_int_in;
            step();
        end

        idle();
        csr_re = 1'b0;
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
